mem_arbiter_rr: RTL and testbench

- Parametrised N-master to 1-slave memory bus arbiter.
- Successor to the two-port instruction/data arbiter; sits between CPU-side masters (prefetch, EU data, DMA, debug) and the single memory/IO bus.
- Adds a configurable port count, selectable fixed-priority or round-robin policy, registered grant, per-port bus lock for atomic sequences, and abort handling.
- Keeps the existing bus protocol: word address [19:1], 16-bit data, access/ack, wr_en, bytesel.

---
 rtl/mem_arbiter_rr_pkg.sv | 9 +
 rtl/mem_arbiter_rr_if.sv | 32 +++
 rtl/mem_arbiter_rr_picker.sv | 23 ++
 rtl/mem_arbiter_rr.sv | 63 ++++++
 tb/tb_mem_arbiter_rr.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_rr_pkg.sv
// mem_arb_pkg: shared types and constants for the N-master memory bus arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} arb_state_e;
  function automatic int clog2_ports(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if: per-master request bundle plus the single slave-side bus
interface mem_arbiter_rr_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [NUM_PORTS*ADDR_W-1:0] m_addr;
  logic [NUM_PORTS*DATA_W-1:0] m_data_out;
  logic [NUM_PORTS*DATA_W-1:0] m_data_in;
  logic [NUM_PORTS-1:0] m_access;
  logic [NUM_PORTS-1:0] m_ack;
  logic [NUM_PORTS-1:0] m_wr_en;
  logic [NUM_PORTS*2-1:0] m_bytesel;
  logic [NUM_PORTS-1:0] m_lock;
  logic [ADDR_W-1:0] q_m_addr;
  logic [DATA_W-1:0] q_m_data_in;
  logic [DATA_W-1:0] q_m_data_out;
  logic q_m_access;
  logic q_m_ack;
  logic q_m_wr_en;
  logic [1:0] q_m_bytesel;
  modport master (
    output m_addr, m_data_out, m_access, m_wr_en, m_bytesel, m_lock, q_m_data_in, q_m_ack,
    input m_data_in, m_ack, q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel
  );
  modport slave (
    input m_addr, m_data_out, m_access, m_wr_en, m_bytesel, m_lock, q_m_data_in, q_m_ack,
    output m_data_in, m_ack, q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel
  );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// rr_priority_picker: first requester at or after the rotation base, wrapping
module rr_priority_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [clog2_ports(NUM_PORTS)-1:0] last,
  input  logic rr_en,
  output logic valid,
  output logic [clog2_ports(NUM_PORTS)-1:0] idx
);
  localparam int IW = clog2_ports(NUM_PORTS);
  int base;
  assign base = rr_en ? (int'(last) + 1) % NUM_PORTS : 0;
  assign valid = |req;
  // scan from the farthest offset down so the nearest requester overwrites last
  always_comb begin
    idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--)
      if (req[(base + k) % NUM_PORTS]) idx = IW'((base + k) % NUM_PORTS);
  end
endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-master to 1-slave memory bus arbiter with lock and abort
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ROUND_ROBIN = 1,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  mem_arbiter_rr_if.slave bus,
  output logic [clog2_ports(NUM_PORTS)-1:0] grant_idx
);
  localparam int IW = clog2_ports(NUM_PORTS);
  arb_state_e state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, rr_last_q, rr_last_d, pick_idx;
  logic pick_valid, own_acc, own_lock, busy;
  rr_priority_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req(bus.m_access),
    .last(rr_last_q),
    .rr_en(ROUND_ROBIN != 0),
    .valid(pick_valid),
    .idx(pick_idx)
  );
  assign own_acc = bus.m_access[grant_q];
  assign own_lock = bus.m_lock[grant_q];
  assign busy = state_q != IDLE;
  assign grant_idx = grant_q;
  assign bus.q_m_addr = bus.m_addr[int'(grant_q)*ADDR_W +: ADDR_W];
  assign bus.q_m_data_out = bus.m_data_out[int'(grant_q)*DATA_W +: DATA_W];
  assign bus.q_m_wr_en = bus.m_wr_en[grant_q];
  assign bus.q_m_bytesel = bus.m_bytesel[int'(grant_q)*2 +: 2];
  assign bus.q_m_access = busy & own_acc & ~bus.q_m_ack;
  assign bus.m_ack = busy ? {{(NUM_PORTS-1){1'b0}}, bus.q_m_ack} << grant_q : '0;
  assign bus.m_data_in = {NUM_PORTS{bus.q_m_data_in}};
  // GRANT and LOCKED differ only in whether a dropped request releases the bus
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_last_d = rr_last_q;
    if (state_q == IDLE) begin
      state_d = pick_valid ? GRANT : IDLE;
      grant_d = pick_valid ? pick_idx : grant_q;
    end else if (bus.q_m_ack) begin
      state_d = own_lock ? LOCKED : IDLE;
      rr_last_d = own_lock ? rr_last_q : grant_q;
    end else if (!own_acc && (state_q == GRANT || !own_lock)) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_last_q <= IW'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_last_q <= rr_last_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed checks of round-robin and fixed-priority arbiters
module tb_mem_arbiter_rr;
  import mem_arb_pkg::*;
  localparam int N = 3;
  localparam int AW = 19;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_data_out;
  logic [N-1:0] m_access, m_wr_en, m_lock;
  logic [2*N-1:0] m_bytesel;
  logic [DW-1:0] q_m_data_in;
  logic q_m_ack;
  logic sel_fp;
  logic [1:0] gi_rr, gi_fp;
  int checks = 0;
  int errors = 0;
  mem_arbiter_rr_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) b_rr ();
  mem_arbiter_rr_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) b_fp ();
  assign {b_rr.m_addr, b_rr.m_data_out, b_rr.m_access, b_rr.m_wr_en, b_rr.m_bytesel, b_rr.m_lock, b_rr.q_m_data_in, b_rr.q_m_ack}
    = {m_addr, m_data_out, m_access, m_wr_en, m_bytesel, m_lock, q_m_data_in, q_m_ack};
  assign {b_fp.m_addr, b_fp.m_data_out, b_fp.m_access, b_fp.m_wr_en, b_fp.m_bytesel, b_fp.m_lock, b_fp.q_m_data_in, b_fp.q_m_ack}
    = {m_addr, m_data_out, m_access, m_wr_en, m_bytesel, m_lock, q_m_data_in, q_m_ack};
  mem_arbiter_rr #(.NUM_PORTS(N), .ROUND_ROBIN(1), .ADDR_W(AW), .DATA_W(DW)) dut_rr (
    .clk(clk), .reset_n(reset_n), .bus(b_rr), .grant_idx(gi_rr)
  );
  mem_arbiter_rr #(.NUM_PORTS(N), .ROUND_ROBIN(0), .ADDR_W(AW), .DATA_W(DW)) dut_fp (
    .clk(clk), .reset_n(reset_n), .bus(b_fp), .grant_idx(gi_fp)
  );
  wire [N-1:0] m_ack = sel_fp ? b_fp.m_ack : b_rr.m_ack;
  wire [N*DW-1:0] m_din = sel_fp ? b_fp.m_data_in : b_rr.m_data_in;
  wire q_acc = sel_fp ? b_fp.q_m_access : b_rr.q_m_access;
  wire [AW-1:0] q_addr = sel_fp ? b_fp.q_m_addr : b_rr.q_m_addr;
  wire [DW-1:0] q_dout = sel_fp ? b_fp.q_m_data_out : b_rr.q_m_data_out;
  wire q_we = sel_fp ? b_fp.q_m_wr_en : b_rr.q_m_wr_en;
  wire [1:0] q_bs = sel_fp ? b_fp.q_m_bytesel : b_rr.q_m_bytesel;
  wire [1:0] gi = sel_fp ? gi_fp : gi_rr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m_access = '0;
    m_lock = '0;
    q_m_ack = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  // slave model: waits for a request, acks after lat cycles, master drops access next cycle
  task automatic serve(input int lat, input bit rerq, output int port, output logic [N-1:0] ack, output bit ok);
    ok = 1'b0;
    port = -1;
    ack = '0;
    #1;
    for (int c = 0; c < 20 && !q_acc; c++) tick();
    if (!q_acc) return;
    ok = 1'b1;
    port = int'(gi);
    repeat (lat) tick();
    q_m_ack = 1'b1;
    #1;
    ack = m_ack;
    tick();
    q_m_ack = 1'b0;
    m_access[port] = 1'b0;
    if (rerq) begin
      tick();
      m_access[port] = 1'b1;
    end
  endtask

  task automatic test_reset();
    sel_fp = 1'b0;
    m_addr = {19'h33333, 19'h22222, 19'h11111};
    m_data_out = {16'hc2c2, 16'hb1b1, 16'ha0a0};
    m_wr_en = 3'b010;
    m_bytesel = {2'b11, 2'b10, 2'b01};
    q_m_data_in = 16'h5a5a;
    m_access = '0;
    m_lock = '0;
    q_m_ack = 1'b0;
    repeat (2) tick();
    checks++; if (m_ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b exp 000", m_ack); end
    checks++; if (q_acc !== 1'b0) begin errors++; $display("FAIL reset_qacc: got %b exp 0", q_acc); end
    checks++; if (gi_rr !== 2'd0) begin errors++; $display("FAIL reset_gi_rr: got %0d exp 0", gi_rr); end
    checks++; if (gi_fp !== 2'd0) begin errors++; $display("FAIL reset_gi_fp: got %0d exp 0", gi_fp); end
    reset_n = 1'b1;
    tick();
    q_m_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 3'b000) begin errors++; $display("FAIL idle_ack_ignored: got %b exp 000", m_ack); end
    tick();
    q_m_ack = 1'b0;
    #1;
    checks++; if (q_acc !== 1'b0) begin errors++; $display("FAIL idle_after_stray_ack: got %b exp 0", q_acc); end
  endtask

  task automatic test_single();
    sel_fp = 1'b0;
    do_reset();
    m_access = 3'b010;
    #1;
    checks++; if (q_acc !== 1'b0) begin errors++; $display("FAIL single_idle_qacc: got %b exp 0", q_acc); end
    tick();
    checks++; if (q_acc !== 1'b1) begin errors++; $display("FAIL single_qacc_rise: got %b exp 1", q_acc); end
    checks++; if (gi !== 2'd1) begin errors++; $display("FAIL single_grant: got %0d exp 1", gi); end
    checks++; if (q_addr !== 19'h22222) begin errors++; $display("FAIL single_addr: got %h exp 22222", q_addr); end
    checks++; if (q_dout !== 16'hb1b1) begin errors++; $display("FAIL single_wdata: got %h exp b1b1", q_dout); end
    checks++; if ({q_we, q_bs} !== 3'b110) begin errors++; $display("FAIL single_we_bs: got %b exp 110", {q_we, q_bs}); end
    tick();
    checks++; if (m_ack !== 3'b000) begin errors++; $display("FAIL single_early_ack: got %b exp 000", m_ack); end
    tick();
    q_m_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 3'b010) begin errors++; $display("FAIL single_ack: got %b exp 010", m_ack); end
    checks++; if (q_acc !== 1'b0) begin errors++; $display("FAIL single_qacc_at_ack: got %b exp 0", q_acc); end
    checks++; if (m_din !== {3{16'h5a5a}}) begin errors++; $display("FAIL single_rdata: got %h exp 5a5a5a5a5a5a", m_din); end
    tick();
    q_m_ack = 1'b0;
    m_access = 3'b000;
    #1;
    checks++; if (m_ack !== 3'b000) begin errors++; $display("FAIL single_ack_one_cycle: got %b exp 000", m_ack); end
  endtask

  task automatic test_rr_rotation();
    int p;
    logic [N-1:0] a, exp_a;
    bit ok;
    sel_fp = 1'b0;
    do_reset();
    m_access = 3'b111;
    for (int i = 0; i < 6; i++) begin
      serve(1, 1'b1, p, a, ok);
      exp_a = 3'b001 << (i % 3);
      checks++; if (!ok || p != i % 3) begin errors++; $display("FAIL rr_order[%0d]: got %0d exp %0d", i, p, i % 3); end
      checks++; if (a !== exp_a) begin errors++; $display("FAIL rr_ack[%0d]: got %b exp %b", i, a, exp_a); end
    end
    m_access = '0;
    do_reset();
    m_access = 3'b001;
    serve(1, 1'b0, p, a, ok);
    checks++; if (!ok || p != 0) begin errors++; $display("FAIL rr_solo0: got %0d exp 0", p); end
    m_access = 3'b101;
    serve(1, 1'b0, p, a, ok);
    checks++; if (!ok || p != 2) begin errors++; $display("FAIL rr_after0_picks2: got %0d exp 2", p); end
    m_access = '0;
  endtask

  task automatic test_fixed_priority();
    int p;
    logic [N-1:0] a;
    bit ok;
    sel_fp = 1'b1;
    do_reset();
    m_access = 3'b001;
    serve(1, 1'b0, p, a, ok);
    checks++; if (!ok || p != 0) begin errors++; $display("FAIL fp_solo0: got %0d exp 0", p); end
    m_access = 3'b101;
    serve(1, 1'b0, p, a, ok);
    checks++; if (!ok || p != 0) begin errors++; $display("FAIL fp_port0_wins: got %0d exp 0", p); end
    checks++; if (a !== 3'b001) begin errors++; $display("FAIL fp_ack0: got %b exp 001", a); end
    serve(1, 1'b0, p, a, ok);
    checks++; if (!ok || p != 2) begin errors++; $display("FAIL fp_port2_after: got %0d exp 2", p); end
    checks++; if (a !== 3'b100) begin errors++; $display("FAIL fp_ack2: got %b exp 100", a); end
    m_access = '0;
    sel_fp = 1'b0;
  endtask

  task automatic test_lock();
    int p;
    logic [N-1:0] a;
    bit ok;
    sel_fp = 1'b0;
    do_reset();
    m_access = 3'b100;
    m_lock = 3'b100;
    tick();
    m_access[0] = 1'b1;
    serve(1, 1'b1, p, a, ok);
    checks++; if (!ok || p != 2 || a !== 3'b100) begin errors++; $display("FAIL lock_first: got port %0d ack %b exp port 2 ack 100", p, a); end
    #1;
    checks++; if (q_acc !== 1'b1 || gi !== 2'd2) begin errors++; $display("FAIL lock_held: got acc %b gi %0d exp acc 1 gi 2", q_acc, gi); end
    m_lock[2] = 1'b0;
    serve(1, 1'b0, p, a, ok);
    checks++; if (!ok || p != 2 || a !== 3'b100) begin errors++; $display("FAIL lock_second: got port %0d ack %b exp port 2 ack 100", p, a); end
    tick();
    checks++; if (q_acc !== 1'b1 || gi !== 2'd0) begin errors++; $display("FAIL lock_release_grant0: got acc %b gi %0d exp acc 1 gi 0", q_acc, gi); end
    serve(1, 1'b0, p, a, ok);
    checks++; if (!ok || a !== 3'b001) begin errors++; $display("FAIL lock_port0_ack: got %b exp 001", a); end
    m_access = '0;
  endtask

  task automatic test_abort();
    int p;
    logic [N-1:0] a;
    bit ok;
    sel_fp = 1'b0;
    do_reset();
    m_access = 3'b010;
    tick();
    checks++; if (q_acc !== 1'b1 || gi !== 2'd1) begin errors++; $display("FAIL abort_grant: got acc %b gi %0d exp acc 1 gi 1", q_acc, gi); end
    m_access = 3'b000;
    #1;
    checks++; if (q_acc !== 1'b0) begin errors++; $display("FAIL abort_qacc_drop: got %b exp 0", q_acc); end
    checks++; if (m_ack !== 3'b000) begin errors++; $display("FAIL abort_no_ack: got %b exp 000", m_ack); end
    tick();
    m_access = 3'b101;
    #1;
    checks++; if (q_acc !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b exp 0", q_acc); end
    tick();
    checks++; if (q_acc !== 1'b1 || gi !== 2'd0) begin errors++; $display("FAIL abort_rr_last_kept: got acc %b gi %0d exp acc 1 gi 0", q_acc, gi); end
    serve(1, 1'b0, p, a, ok);
    m_access = '0;
  endtask

  task automatic test_reset_mid();
    int p;
    logic [N-1:0] a;
    bit ok;
    sel_fp = 1'b0;
    do_reset();
    m_access = 3'b010;
    tick();
    tick();
    q_m_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 3'b010) begin errors++; $display("FAIL mid_ack_before: got %b exp 010", m_ack); end
    reset_n = 1'b0;
    #1;
    checks++; if (m_ack !== 3'b000) begin errors++; $display("FAIL mid_ack_cleared: got %b exp 000", m_ack); end
    checks++; if (q_acc !== 1'b0) begin errors++; $display("FAIL mid_qacc_cleared: got %b exp 0", q_acc); end
    checks++; if (gi !== 2'd0) begin errors++; $display("FAIL mid_gi_cleared: got %0d exp 0", gi); end
    tick();
    reset_n = 1'b1;
    q_m_ack = 1'b0;
    tick();
    checks++; if (q_acc !== 1'b1 || gi !== 2'd1) begin errors++; $display("FAIL mid_resume: got acc %b gi %0d exp acc 1 gi 1", q_acc, gi); end
    serve(1, 1'b0, p, a, ok);
    checks++; if (!ok || a !== 3'b010) begin errors++; $display("FAIL mid_resume_ack: got %b exp 010", a); end
    m_access = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_rotation();
    test_fixed_priority();
    test_lock();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
